// File: rtl/shift_serdes_pkg.sv
// shift_serdes shared types: FSM states and shift direction.
// Optional parity stage is enabled by the SHIFT_PARITY_EN macro.
package shift_serdes_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } dir_e;

endpackage

// File: rtl/shift_serdes_core.sv
// Bidirectional shift register with parallel load.
// Serial data enters the end opposite the one being transmitted.
module shift_core
  import shift_serdes_pkg::*;
#(
  parameter int NBITS_DATA = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic                  dir_i,
  input  logic [NBITS_DATA-1:0] data_i,
  input  logic                  sin_i,
  output logic                  sout_o,
  output logic [NBITS_DATA-1:0] nxt_o
);

  logic [NBITS_DATA-1:0] shreg_q;
  logic [NBITS_DATA-1:0] shreg_d;
  logic                  msb_first;

  assign msb_first = (dir_e'(dir_i) == MSB_FIRST);

  always_comb begin
    nxt_o = {sin_i, shreg_q[NBITS_DATA-1:1]};
    if (msb_first) begin
      nxt_o = {shreg_q[NBITS_DATA-2:0], sin_i};
    end
  end

  assign sout_o = msb_first ? shreg_q[NBITS_DATA-1]
                            : shreg_q[0];

  always_comb begin
    shreg_d = shreg_q;
    if (load_i) begin
      shreg_d = data_i;
    end else if (shift_i) begin
      shreg_d = nxt_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: rtl/shift_serdes.sv
// Parallel<->serial frame converter with valid/ready load.
// Define SHIFT_PARITY_EN to append an even-parity bit per frame.
module shift_serdes
  import shift_serdes_pkg::*;
#(
  parameter  int NBITS_DATA = 8,
  localparam int CNT_W      = $clog2(NBITS_DATA)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [NBITS_DATA-1:0] din,
  input  logic                  dir,
  input  logic                  serial_in,
  output logic                  serial_out,
  output logic                  busy,
  output logic                  done,
  output logic [NBITS_DATA-1:0] dout,
  output logic                  parity_err
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBITS_DATA - 1);

  state_e                state_q;
  state_e                state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic                  dir_q;
  logic                  dir_d;
  logic [NBITS_DATA-1:0] dout_q;
  logic [NBITS_DATA-1:0] dout_d;
  logic                  accept;
  logic                  core_sout;
  logic [NBITS_DATA-1:0] core_nxt;

  assign accept = load_valid & load_ready;

  shift_core #(
    .NBITS_DATA(NBITS_DATA)
  ) u_core (
    .clk    (clk),
    .rst_n  (reset),
    .load_i (accept),
    .shift_i(state_q == SHIFT),
    .dir_i  (dir_q),
    .data_i (din),
    .sin_i  (serial_in),
    .sout_o (core_sout),
    .nxt_o  (core_nxt)
  );

`ifdef SHIFT_PARITY_EN
  logic par_q;
  logic perr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      if (accept) begin
        par_q <= ^din;
      end
      // dout already holds the new word while in PARITY
      if (state_q == PARITY) begin
        perr_q <= (^dout_q) ^ serial_in;
      end
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    dout_d     = dout_q;
    load_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    serial_out = 1'b1;
    unique case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          dir_d   = dir;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy       = 1'b1;
        serial_out = core_sout;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d  = '0;
          dout_d = core_nxt;
`ifdef SHIFT_PARITY_EN
          state_d = PARITY;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef SHIFT_PARITY_EN
      PARITY: begin
        busy       = 1'b1;
        serial_out = par_q;
        state_d    = DONE;
      end
`endif
      DONE: begin
        done       = 1'b1;
        load_ready = 1'b1;
        state_d    = IDLE;
        if (load_valid) begin
          dir_d   = dir;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      dout_q  <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule
